dcache_arbiter: RTL and testbench

- Shares the single dcache memory port between two requesters: the memory-instruction unit (regfile load/store, high priority) and the DMA engine (low priority, starvation-protected).
- Issues at most one access per cycle to the dcache memory.
- Tracks in-flight reads through a fixed-latency tag pipeline so each read response returns to the requester that issued it.
- Sits between the execute/DMA front ends and dcache_mem_high_priority.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_rd_tag_pipe.sv | 44 ++++
 rtl/dcache_arbiter.sv | 150 +++++++++++++++
 tb/tb_dcache_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants and types for the dcache port arbiter.
//   DC_DW         data width (one 4x4 tile of 18-bit elements)
//   DC_AW         address width (10 + LOGCNT, LOGCNT = 5)
//   DC_RD_LAT     dcache memory read latency, issue to valid read data
//   DC_STARVE_MAX DMA waiting cycles before DMA is forced through
//   dc_req_t      one request as seen by the memory port
//   src_e         which requester a read belongs to
package dcache_pkg;

   localparam int DC_DW         = 288;
   localparam int DC_AW         = 15;
   localparam int DC_RD_LAT     = 3;
   localparam int DC_STARVE_MAX = 7;

   typedef struct packed {
      logic             we;
      logic [DC_AW-1:0] addr;
      logic [DC_DW-1:0] dat_w;
   } dc_req_t;

   typedef enum logic {
      SRC_MEM = 1'b0,
      SRC_DMA = 1'b1
   } src_e;

endpackage

// File: rtl/dcache_rd_tag_pipe.sv
// dcache_rd_tag_pipe: RD_LAT-deep shift register of {vld, src} that follows
// each issued read down the fixed-latency dcache pipeline, so the data that
// appears RD_LAT cycles later can be steered back to its requester.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears all valids)
//   in_vld      a read is issued this cycle
//   in_src      requester of that read
//   out_vld     the read issued RD_LAT cycles ago returns this cycle
//   out_src     requester of the returning read
module dcache_rd_tag_pipe
   import dcache_pkg::*;
#(
   parameter int RD_LAT = DC_RD_LAT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_vld,
   input  src_e in_src,
   output logic out_vld,
   output src_e out_src
);

   logic [RD_LAT-1:0] vld_pipe;
   logic [RD_LAT-1:0] src_pipe;

   // Stage 0 loads every cycle; a bubble simply shifts in vld = 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         src_pipe <= '0;
      end else begin
         vld_pipe[0] <= in_vld;
         src_pipe[0] <= in_src;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            src_pipe[i] <= src_pipe[i-1];
         end
      end
   end

   assign out_vld = vld_pipe[RD_LAT-1];
   assign out_src = src_e'(src_pipe[RD_LAT-1]);

endmodule

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: shares the single dcache memory port between the
// memory-instruction unit (high priority) and the DMA engine (low priority,
// protected from starvation). At most one access is issued per cycle; reads
// are tagged with their source and the data returned RD_LAT cycles later is
// routed back to the issuing requester, in issue order.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   mem_valid/ready/we/addr/dat_w   memory-instruction request handshake
//   mem_rvalid, mem_dat_r    memory-instruction load response
//   dma_valid/ready/we/addr/dat_w   DMA request handshake
//   dma_rvalid, dma_dat_r    DMA read response
//   dc_addr, dc_we, dc_re, dc_dat_w  issue side of the dcache memory
//   dc_dat_r                 dcache read data, valid RD_LAT cycles after dc_re
module dcache_arbiter
   import dcache_pkg::*;
#(
   parameter int DW         = DC_DW,
   parameter int AW         = DC_AW,
   parameter int RD_LAT     = DC_RD_LAT,
   parameter int STARVE_MAX = DC_STARVE_MAX
) (
   input  logic          clk,
   input  logic          rst_n,
   // memory-instruction requester
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic          mem_we,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_dat_w,
   output logic          mem_rvalid,
   output logic [DW-1:0] mem_dat_r,
   // DMA requester
   input  logic          dma_valid,
   output logic          dma_ready,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_dat_w,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_dat_r,
   // dcache memory port
   output logic [AW-1:0] dc_addr,
   output logic          dc_we,
   output logic          dc_re,
   output logic [DW-1:0] dc_dat_w,
   input  logic [DW-1:0] dc_dat_r
);

   dc_req_t    mem_req;
   dc_req_t    dma_req;
   dc_req_t    iss_req;

   logic [7:0] starve_cnt;
   logic       dma_pri;
   logic       gnt_mem;
   logic       gnt_dma;
   logic       granted;
   src_e       sel;
   src_e       sel_q;

   logic       tag_vld;
   src_e       tag_src;

   assign mem_req = {mem_we, mem_addr, mem_dat_w};
   assign dma_req = {dma_we, dma_addr, dma_dat_w};

   // ---------------------------------------------------------------------
   // Grant. DMA only overtakes a contending mem request once it has waited
   // STARVE_MAX cycles. rst_n gates both grants so nothing is accepted or
   // issued while reset is held.
   // ---------------------------------------------------------------------
   assign dma_pri = (starve_cnt == 8'(STARVE_MAX));

   always_comb begin
      gnt_mem = 1'b0;
      gnt_dma = 1'b0;
      if (rst_n) begin
         if (mem_valid && dma_valid) begin
            gnt_dma = dma_pri;
            gnt_mem = !dma_pri;
         end else begin
            gnt_mem = mem_valid;
            gnt_dma = dma_valid;
         end
      end
   end

   assign granted   = gnt_mem || gnt_dma;
   assign mem_ready = gnt_mem;
   assign dma_ready = gnt_dma;

   // ---------------------------------------------------------------------
   // Starvation counter. Counts cycles DMA sits valid but not accepted;
   // any DMA grant or a dropped dma_valid restarts the count. The cycle it
   // reaches STARVE_MAX only blocks, the override applies from the next.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!dma_valid || gnt_dma) begin
         starve_cnt <= '0;
      end else if (!dma_pri) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Issue mux. On idle cycles the select stays on the last issued source
   // so the wide address/data bus does not flip between requesters.
   // ---------------------------------------------------------------------
   always_comb begin
      sel = sel_q;
      if (gnt_dma)      sel = SRC_DMA;
      else if (gnt_mem) sel = SRC_MEM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       sel_q <= SRC_MEM;
      else if (granted) sel_q <= sel;
   end

   assign iss_req  = (sel == SRC_DMA) ? dma_req : mem_req;

   assign dc_addr  = rst_n ? iss_req.addr  : '0;
   assign dc_dat_w = rst_n ? iss_req.dat_w : '0;
   assign dc_we    = granted &&  iss_req.we;
   assign dc_re    = granted && !iss_req.we;

   // ---------------------------------------------------------------------
   // Read return path. The tag pipe lines up with the dcache read latency,
   // so its output qualifies dc_dat_r in the same cycle.
   // ---------------------------------------------------------------------
   dcache_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (dc_re),
      .in_src  (gnt_dma ? SRC_DMA : SRC_MEM),
      .out_vld (tag_vld),
      .out_src (tag_src)
   );

   assign mem_rvalid = tag_vld && (tag_src == SRC_MEM);
   assign dma_rvalid = tag_vld && (tag_src == SRC_DMA);

   // Data is zeroed outside the response pulse so nothing stale leaks out.
   assign mem_dat_r  = mem_rvalid ? dc_dat_r : '0;
   assign dma_dat_r  = dma_rvalid ? dc_dat_r : '0;

endmodule

// File: tb/tb_dcache_arbiter.sv
module tb_dcache_arbiter;
   import dcache_pkg::*;

   localparam int DW = DC_DW;
   localparam int AW = DC_AW;
   localparam int RL = DC_RD_LAT;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_valid, mem_ready, mem_we, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dat_w, mem_dat_r;
   logic          dma_valid, dma_ready, dma_we, dma_rvalid;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_dat_w, dma_dat_r;
   logic [AW-1:0] dc_addr;
   logic          dc_we, dc_re;
   logic [DW-1:0] dc_dat_w, dc_dat_r;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dcache_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_dat_w  (mem_dat_w),
      .mem_rvalid (mem_rvalid),
      .mem_dat_r  (mem_dat_r),
      .dma_valid  (dma_valid),
      .dma_ready  (dma_ready),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_dat_w  (dma_dat_w),
      .dma_rvalid (dma_rvalid),
      .dma_dat_r  (dma_dat_r),
      .dc_addr    (dc_addr),
      .dc_we      (dc_we),
      .dc_re      (dc_re),
      .dc_dat_w   (dc_dat_w),
      .dc_dat_r   (dc_dat_r)
   );

   // Contents of a never-written location: derived from its address.
   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return {9{16'hA5A5, 1'b0, a}};
   endfunction

   // dcache memory stand-in with RD_LAT read latency
   logic [DW-1:0] smem [int];
   logic [DW-1:0] rpipe [RL];

   always @(posedge clk) begin
      rpipe[0] <= dc_re ? (smem.exists(int'(dc_addr)) ? smem[int'(dc_addr)] : dflt(dc_addr)) : '0;
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
      if (dc_we) smem[int'(dc_addr)] = dc_dat_w;
   end
   assign dc_dat_r = rpipe[RL-1];

   // reference model for the random phase
   logic [DW-1:0] ref_mem [int];
   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } exp_t;
   exp_t mq[$];
   exp_t dq[$];

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_dat_w = '0;
      dma_valid = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_dat_w = '0;
   endtask

   logic mem_hs, dma_hs, exp_mv, exp_dv;
   exp_t e;

   initial begin
      // ---------------- reset state, requests held high ----------------
      idle();
      rst_n     = 1'b0;
      mem_valid = 1'b1; mem_addr = 15'h1234; mem_dat_w = '1;
      dma_valid = 1'b1; dma_addr = 15'h0777;
      @(negedge clk);
      @(negedge clk);
      chk1("rst_mem_ready",  mem_ready,  1'b0);
      chk1("rst_dma_ready",  dma_ready,  1'b0);
      chk1("rst_mem_rvalid", mem_rvalid, 1'b0);
      chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
      chkd("rst_mem_dat_r",  mem_dat_r,  '0);
      chkd("rst_dma_dat_r",  dma_dat_r,  '0);
      chk1("rst_dc_we",      dc_we,      1'b0);
      chk1("rst_dc_re",      dc_re,      1'b0);
      chkd("rst_dc_addr",    DW'(dc_addr), '0);
      chkd("rst_dc_dat_w",   dc_dat_w,   '0);
      tick();
      idle();
      rst_n = 1'b1;
      tick();
      tick();

      // ---------------- single mem load at 0x0010 ----------------
      mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 15'h0010;
      @(negedge clk);
      chk1("t1_mem_ready", mem_ready, 1'b1);
      chk1("t1_dma_ready", dma_ready, 1'b0);
      chk1("t1_dc_re",     dc_re,     1'b1);
      chk1("t1_dc_we",     dc_we,     1'b0);
      chkd("t1_dc_addr",   DW'(dc_addr), DW'(15'h0010));
      tick();
      idle();
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         chk1("t1_mem_rvalid_early", mem_rvalid, 1'b0);
         tick();
      end
      @(negedge clk);
      chk1("t1_mem_rvalid", mem_rvalid, 1'b1);
      chkd("t1_mem_dat_r",  mem_dat_r,  dflt(15'h0010));
      chk1("t1_dma_rvalid", dma_rvalid, 1'b0);
      tick();
      @(negedge clk);
      chk1("t1_mem_rvalid_once", mem_rvalid, 1'b0);
      tick();

      // ---------------- DMA write then read-back of 0x0020 ----------------
      dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 15'h0020; dma_dat_w = DW'(12'hABC);
      @(negedge clk);
      chk1("t2_wr_ready", dma_ready, 1'b1);
      chk1("t2_dc_we",    dc_we,     1'b1);
      tick();
      dma_we = 1'b0; dma_dat_w = '0;
      @(negedge clk);
      chk1("t2_rd_ready", dma_ready, 1'b1);
      chk1("t2_dc_re",    dc_re,     1'b1);
      tick();
      idle();
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         chk1("t2_dma_rvalid_early", dma_rvalid, 1'b0);
         tick();
      end
      @(negedge clk);
      chk1("t2_dma_rvalid", dma_rvalid, 1'b1);
      chkd("t2_dma_dat_r",  dma_dat_r,  DW'(12'hABC));
      chk1("t2_mem_rvalid", mem_rvalid, 1'b0);
      tick();

      // ---------------- contention: 7 mem grants then 1 DMA grant ----------------
      mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 15'h0100; mem_dat_w = DW'(32'h1111);
      dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 15'h0200; dma_dat_w = DW'(32'h2222);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk1("t3_dma_ready", dma_ready, (i % 8) == 7);
         chk1("t3_mem_ready", mem_ready, (i % 8) != 7);
         if (i == 8) chkd("t3_starve_clr", DW'(dut.starve_cnt), '0);
         if (i == 7) chkd("t3_starve_max", DW'(dut.starve_cnt), DW'(7));
         tick();
      end
      idle();
      tick();

      // ---------------- interleaved reads mem@1, dma@2, mem@3 ----------------
      mem_valid = 1'b1; mem_addr = 15'h0001;
      tick();
      idle(); dma_valid = 1'b1; dma_addr = 15'h0002;
      tick();
      idle(); mem_valid = 1'b1; mem_addr = 15'h0003;
      tick();
      idle();
      @(negedge clk);
      chk1("t4_r0_mem_rvalid", mem_rvalid, 1'b1);
      chk1("t4_r0_dma_rvalid", dma_rvalid, 1'b0);
      chkd("t4_r0_mem_dat_r",  mem_dat_r,  dflt(15'h0001));
      tick();
      @(negedge clk);
      chk1("t4_r1_dma_rvalid", dma_rvalid, 1'b1);
      chk1("t4_r1_mem_rvalid", mem_rvalid, 1'b0);
      chkd("t4_r1_dma_dat_r",  dma_dat_r,  dflt(15'h0002));
      tick();
      @(negedge clk);
      chk1("t4_r2_mem_rvalid", mem_rvalid, 1'b1);
      chk1("t4_r2_dma_rvalid", dma_rvalid, 1'b0);
      chkd("t4_r2_mem_dat_r",  mem_dat_r,  dflt(15'h0003));
      tick();

      // ---------------- reset with reads in flight ----------------
      mem_valid = 1'b1; mem_addr = 15'h0001;
      tick();
      idle(); dma_valid = 1'b1; dma_addr = 15'h0002;
      tick();
      idle();
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("t5_rst_mem_rvalid", mem_rvalid, 1'b0);
         chk1("t5_rst_dma_rvalid", dma_rvalid, 1'b0);
         chk1("t5_rst_dc_re",      dc_re,      1'b0);
         tick();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1("t5_no_mem_rvalid", mem_rvalid, 1'b0);
         chk1("t5_no_dma_rvalid", dma_rvalid, 1'b0);
         tick();
      end
      mem_valid = 1'b1; mem_addr = 15'h0003;
      @(negedge clk);
      chk1("t5_fresh_ready", mem_ready, 1'b1);
      tick();
      idle();
      tick();
      tick();
      @(negedge clk);
      chk1("t5_fresh_rvalid", mem_rvalid, 1'b1);
      chkd("t5_fresh_dat_r",  mem_dat_r,  dflt(15'h0003));
      tick();

      // ---------------- random traffic against the reference model ----------------
      mem_hs = 1'b0;
      dma_hs = 1'b0;
      for (int cyc = 0; cyc < 10000 + RL + 3; cyc++) begin
         tick();
         if (cyc >= 10000) begin
            mem_valid = 1'b0;
            dma_valid = 1'b0;
         end else begin
            if (!mem_valid || mem_hs) begin
               mem_valid = ($urandom_range(0, 99) < 50);
               mem_we    = ($urandom_range(0, 2) == 0);
               mem_addr  = 15'h0400 + 15'($urandom_range(0, 15));
               mem_dat_w = rnd_data();
            end
            if (!dma_valid || dma_hs) begin
               dma_valid = ($urandom_range(0, 99) < 40);
               dma_we    = ($urandom_range(0, 1) == 0);
               dma_addr  = 15'h0400 + 15'($urandom_range(0, 15));
               dma_dat_w = rnd_data();
            end
         end
         @(negedge clk);
         chk1("rnd_one_ready", mem_ready && dma_ready, 1'b0);
         exp_mv = (mq.size() > 0) && (mq[0].due == cyc);
         exp_dv = (dq.size() > 0) && (dq[0].due == cyc);
         chk1("rnd_mem_rvalid", mem_rvalid, exp_mv);
         chk1("rnd_dma_rvalid", dma_rvalid, exp_dv);
         if (exp_mv) begin
            e = mq.pop_front();
            chkd("rnd_mem_dat_r", mem_dat_r, e.d);
         end
         if (exp_dv) begin
            e = dq.pop_front();
            chkd("rnd_dma_dat_r", dma_dat_r, e.d);
         end
         mem_hs = mem_valid && mem_ready;
         dma_hs = dma_valid && dma_ready;
         if (mem_hs) begin
            if (mem_we) ref_mem[int'(mem_addr)] = mem_dat_w;
            else begin
               e.due = cyc + RL; e.d = ref_rd(mem_addr);
               mq.push_back(e);
            end
         end
         if (dma_hs) begin
            if (dma_we) ref_mem[int'(dma_addr)] = dma_dat_w;
            else begin
               e.due = cyc + RL; e.d = ref_rd(dma_addr);
               dq.push_back(e);
            end
         end
      end
      chkd("rnd_mem_drained", DW'(mq.size()), '0);
      chkd("rnd_dma_drained", DW'(dq.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
